// File: rtl/pong_pkg.sv
// Shared pong definitions: game_state encoding, winner codes and default game constants.
// Imported by the game controller and by the score/text overlay so both decode game_state identically.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam int DEF_WIN_SCORE   = 9;
    localparam int DEF_DELAY_TICKS = 120;

    localparam logic [3:0] SCORE_MAX = 4'd9;

    // Single BCD digit increment that sticks at 9 instead of wrapping.
    function automatic logic [3:0] bcd_inc_sat(input logic [3:0] s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_tick_timer.sv
// Loadable down-counter that steps once per refresh tick and stops at zero.
// A load on the same cycle as a tick takes precedence over the decrement.
module pong_tick_timer #(
    parameter int TMR_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [TMR_W-1:0] count;

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (tick && !zero)
            count <= count - TMR_W'(1);
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: serve/pause sequencing, BCD scoring and winner detection.
// Optional SERVE_WAIT_EN: after a point, the next serve waits for a button press once the pause expires.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int DELAY_TICKS = DEF_DELAY_TICKS,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] btn,
    input  logic       refresh_tick,
    input  logic       miss1,
    input  logic       miss2,
    output logic       gra_still,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] game_state,
    output logic [1:0] winner,
    output logic       point_pulse
);

    localparam logic [3:0]       WIN_CODE   = 4'(WIN_SCORE);
    localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(DELAY_TICKS);

    state_t     state, state_next;
    logic [3:0] btn_meta, btn_sync;
    logic       start_prev, start_edge;
    logic       tmr_zero, award, win_hit, clear_game;
    logic [3:0] score1_inc, score2_inc, score1_d, score2_d;
    logic [1:0] winner_d;
    logic       gra_still_d;

    // NOTE: every flop here uses <= so all registers sample the pre-edge values and the
    // two synchronizer stages really are two distinct stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta   <= '0;
            btn_sync   <= '0;
            start_prev <= 1'b0;
        end else begin
            btn_meta   <= btn;
            btn_sync   <= btn_meta;
            start_prev <= |btn_sync;
        end
    end

    assign start_edge = (|btn_sync) & ~start_prev;

    pong_tick_timer #(.TMR_W(TMR_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (award),
        .load_val (DELAY_LOAD),
        .tick     (refresh_tick),
        .zero     (tmr_zero)
    );

    assign score1_inc = bcd_inc_sat(score1);
    assign score2_inc = bcd_inc_sat(score2);
    // Only the PLAY state scores, so persisting miss levels cannot award twice.
    assign award      = (state == ST_PLAY) && (miss1 || miss2);
    assign win_hit    = miss1 ? (score1_inc == WIN_CODE) : (score2_inc == WIN_CODE);
    assign clear_game = (state == ST_OVER) && tmr_zero && start_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_NEWGAME;
        else
            state <= state_next;
    end

    // NOTE: state_next is defaulted before the case so every path assigns it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_NEWGAME: if (start_edge) state_next = ST_PLAY;
            ST_PLAY:    if (award) state_next = win_hit ? ST_OVER : ST_NEWBALL;
`ifdef SERVE_WAIT_EN
            ST_NEWBALL: if (tmr_zero && start_edge) state_next = ST_PLAY;
`else
            ST_NEWBALL: if (tmr_zero) state_next = ST_PLAY;
`endif
            ST_OVER:    if (clear_game) state_next = ST_NEWGAME;
            default:    state_next = ST_NEWGAME;
        endcase
    end

    always_comb begin
        gra_still_d = (state != ST_PLAY);
        score1_d    = score1;
        score2_d    = score2;
        winner_d    = winner;
        if (clear_game) begin
            score1_d = '0;
            score2_d = '0;
            winner_d = WIN_NONE;
        end else if (award) begin
            if (miss1)
                score1_d = score1_inc;
            else
                score2_d = score2_inc;
            if (win_hit)
                winner_d = miss1 ? WIN_P1 : WIN_P2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gra_still   <= 1'b1;
            score1      <= '0;
            score2      <= '0;
            winner      <= WIN_NONE;
            point_pulse <= 1'b0;
        end else begin
            gra_still   <= gra_still_d;
            score1      <= score1_d;
            score2      <= score2_d;
            winner      <= winner_d;
            point_pulse <= award;
        end
    end

    assign game_state = state;

endmodule
